// File: rtl/seq_detector_param.sv
// seq_detector_param
// Moore detector for a runtime-programmable serial pattern of 1..PAT_W bits.
// It supports overlapping or non-overlapping matching and keeps a saturating
// count of matches.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst          : synchronous active-high reset; loads RST_PAT/RST_LEN/RST_OVL
//   inp          : serial data bit, taken only when in_valid is high
//   in_valid     : sample qualifier
//   cfg_load     : one-cycle strobe; latches cfg_pat/cfg_len/cfg_ovl and clears
//                  the history, the match flag and the counter
//   cfg_pat      : pattern, bit [len-1] arrives first and bit [0] arrives last
//   cfg_len      : pattern length; 0 is stored as 1, >PAT_W is stored as PAT_W
//   cfg_ovl      : 1 = overlapping detection, 0 = non-overlapping
//   outp         : registered match flag (Moore)
//   match_count  : saturating match counter
//   count_sat    : high while match_count is all ones
module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1010,
  parameter int               RST_LEN = 4,
  parameter logic             RST_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  output logic             outp,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0)          return LEN_W'(1);
    else if (len > PAT_W_L) return PAT_W_L;
    else                    return len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + CNT_W'(1);
  endfunction

  // Configuration registers
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;

  // Detector state. The oldest history bit would be shifted out before it
  // could take part in a comparison, so only PAT_W-1 past bits are stored.
  // Together with the incoming bit they form the full PAT_W-bit window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] seen_q, seen_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] seen_inc;
  logic             hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= RST_PAT;
      len_q   <= clamp_len(LEN_W'(RST_LEN));
      ovl_q   <= RST_OVL;
      hist_q  <= '0;
      seen_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    window = {hist_q, inp};

    // Only the low len bits of the window take part in the comparison.
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end

    // seen saturates at PAT_W; the explicit test avoids wrapping when PAT_W
    // equals 2^LEN_W-1.
    seen_inc = (seen_q == PAT_W_L) ? PAT_W_L : seen_q + LEN_W'(1);
    hit      = ((window & mask) == (pat_q & mask)) && (seen_inc >= len_q);

    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    match_d = match_q;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      // A sample presented together with the load is dropped.
      pat_d   = cfg_pat;
      len_d   = clamp_len(cfg_len);
      ovl_d   = cfg_ovl;
      hist_d  = '0;
      seen_d  = '0;
      match_d = 1'b0;
      cnt_d   = '0;
    end else if (in_valid) begin
      hist_d  = window[PAT_W-2:0];
      match_d = hit;
      // Non-overlap: forget the bits of a completed match so none is reused.
      seen_d  = (hit && !ovl_q) ? '0 : seen_inc;
      if (hit) cnt_d = sat_inc(cnt_q);
    end
  end

  // Output logic
  always_comb begin
    outp        = match_q;
    match_count = cnt_q;
    count_sat   = &cnt_q;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, inp, in_valid, cfg_load, cfg_ovl;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;

  logic       outp_a, sat_a;
  logic [7:0] cnt_a;
  logic       outp_b, sat_b;
  logic [1:0] cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .outp(outp_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .outp(outp_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    inp      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pat  = p;
    cfg_len  = l;
    cfg_ovl  = o;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Sends bits v[n-1] first down to v[0]; exp[i] is outp after bit v[i].
  task automatic send_stream(input string tag, input logic [7:0] v, input int n,
                             input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i]);
      chk($sformatf("%s_bit%0d", tag, n - i), outp_a, exp[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inp = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pat = 8'h00; cfg_len = 4'd0; cfg_ovl = 1'b0;
    do_reset();
    chk("rst_outp", outp_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_sat", sat_a, 0);

    // Reset defaults: 1010, len 4, overlapping
    send_stream("ovl", 8'b1010_1010, 8, 8'b0001_0101);
    chk("ovl_count", cnt_a, 3);

    // Non-overlapping
    load(8'b0000_1010, 4'd4, 1'b0);
    chk("novl_load_count", cnt_a, 0);
    send_stream("novl", 8'b1010_1010, 8, 8'b0001_0001);
    chk("novl_count", cnt_a, 2);

    // Valid gaps: outp holds through idle cycles after the match
    load(8'b0000_1010, 4'd4, 1'b1);
    begin
      logic [3:0] v;
      v = 4'b1010;
      for (int k = 0; k < 4; k++) begin
        send_bit(v[3 - k]);
        for (int j = 0; j < 3; j++) begin
          tick();
          chk($sformatf("gap_b%0d_idle%0d", k + 1, j), outp_a, (k == 3) ? 1 : 0);
        end
      end
    end
    send_bit(1'b1);
    chk("gap_next_outp", outp_a, 0);
    chk("gap_count", cnt_a, 1);

    // 8-bit pattern, full length
    load(8'b1100_0111, 4'd8, 1'b1);
    send_stream("len8", 8'b1100_0111, 8, 8'b0000_0001);
    chk("len8_count", cnt_a, 1);

    // cfg_len 15 clamps to 8
    load(8'b1100_0111, 4'd15, 1'b1);
    send_stream("len15", 8'b1100_0111, 8, 8'b0000_0001);
    chk("len15_count", cnt_a, 1);

    // cfg_len 0 clamps to 1
    load(8'b0000_0001, 4'd0, 1'b1);
    send_stream("len0", 8'b0000_0110, 3, 8'b0000_0110);
    chk("len0_count", cnt_a, 2);

    // Reset mid-stream discards the partial match
    do_reset();
    send_stream("rstmid_pre", 8'b0000_0101, 3, 8'b0000_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_count", cnt_a, 0);
    send_bit(1'b0);
    chk("rstmid_outp", outp_a, 0);

    // Load together with a valid sample: sample dropped, history cleared
    send_stream("ldmid_pre", 8'b0000_0101, 3, 8'b0000_0000);
    inp = 1'b0;
    in_valid = 1'b1;
    load(8'b0000_1010, 4'd4, 1'b1);
    in_valid = 1'b0;
    chk("ldmid_outp", outp_a, 0);
    chk("ldmid_count", cnt_a, 0);
    send_bit(1'b0);
    chk("ldmid_after_outp", outp_a, 0);
    chk("ldmid_after_count", cnt_a, 0);

    // Saturation on the 2-bit counter instance
    load(8'b0000_0001, 4'd1, 1'b1);
    chk("sat_load_count", cnt_b, 0);
    chk("sat_load_flag", sat_b, 0);
    for (int i = 1; i <= 6; i++) begin
      send_bit(1'b1);
      chk($sformatf("sat_outp_%0d", i), outp_b, 1);
      chk($sformatf("sat_count_%0d", i), cnt_b, (i < 3) ? i : 3);
    end
    chk("sat_flag", sat_b, 1);
    chk("sat_wide_count", cnt_a, 6);
    chk("sat_wide_flag", sat_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
